// File: rtl/gte_pkg.sv
// Shared definitions for the GTE MAC accumulator slice.
// Holds datapath widths, the FLAG-register bit positions driven by the
// accumulator (bits 30..22), and the accumulator FSM state type.
package gte_pkg;

  localparam int ACC_W    = 44;  // MAC internal accumulator width
  localparam int PROD_W   = 35;  // product width from each multiply lane
  localparam int BIAS_W   = 32;  // TRX/TRY/TRZ or BK/FC width
  localparam int MAC_W    = 32;  // architectural MACn width
  localparam int IR_W     = 16;  // architectural IRn width
  localparam int SF_SHIFT = 12;  // fixed-point shift for sf and bias preload

  // FLAG register positions covered by o_flags[8:0] (o_flags[i] = FLAG[22+i]).
  localparam int FLAG_LSB      = 22;
  localparam int FLAG_MAC1_POS = 30;
  localparam int FLAG_MAC2_POS = 29;
  localparam int FLAG_MAC3_POS = 28;
  localparam int FLAG_MAC1_NEG = 27;
  localparam int FLAG_MAC2_NEG = 26;
  localparam int FLAG_MAC3_NEG = 25;
  localparam int FLAG_IR1_SAT  = 24;
  localparam int FLAG_IR2_SAT  = 23;
  localparam int FLAG_IR3_SAT  = 22;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

endpackage

// File: rtl/gte_mac_lane.sv
// One MAC lane: 44-bit wrapping accumulator with sticky overflow detect,
// sf shift and IR saturation.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en             accepted beat: update accumulator and sticky flags
//   first          beat starts an operation (base from bias or zero)
//   use_bias       with first: preload base with bias<<12
//   sf, lm         shift select and IR lower-clamp select
//   bias, prod     signed bias and signed lane product
//   mac, ir        finalised MACn / IRn for the current beat (combinational)
//   pos_ovf, neg_ovf, sat  flags for the current beat including sticky history
module gte_mac_lane
  import gte_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic              use_bias,
  input  logic              sf,
  input  logic              lm,
  input  logic [BIAS_W-1:0] bias,
  input  logic [PROD_W-1:0] prod,
  output logic [MAC_W-1:0]  mac,
  output logic [IR_W-1:0]   ir,
  output logic              pos_ovf,
  output logic              neg_ovf,
  output logic              sat
);

  logic [ACC_W-1:0]        acc;
  logic                    pos_sticky;
  logic                    neg_sticky;
  logic [ACC_W:0]          base;
  logic [ACC_W:0]          sum;
  logic [ACC_W-1:0]        wrapped;
  logic signed [MAC_W-1:0] mac_s;

  always_comb begin
    if (!first)
      base = {acc[ACC_W-1], acc};
    else if (use_bias)
      base = {{(ACC_W+1-BIAS_W-SF_SHIFT){bias[BIAS_W-1]}}, bias, {SF_SHIFT{1'b0}}};
    else
      base = '0;
  end

  // One guard bit above the accumulator: the two top bits disagreeing means
  // the true sum left the 44-bit signed range.
  assign sum     = base + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
  assign wrapped = sum[ACC_W-1:0];

  // Sticky history is ignored on a first beat so a new operation starts clean.
  assign pos_ovf = (pos_sticky & ~first) | (~sum[ACC_W] &  sum[ACC_W-1]);
  assign neg_ovf = (neg_sticky & ~first) | ( sum[ACC_W] & ~sum[ACC_W-1]);

  // Low 32 bits of (wrapped >>> 12) are exactly wrapped[43:12].
  assign mac_s = sf ? wrapped[SF_SHIFT +: MAC_W] : wrapped[MAC_W-1:0];
  assign mac   = mac_s;

  always_comb begin
    ir  = mac_s[IR_W-1:0];
    sat = 1'b0;
    if (mac_s > 32'sd32767) begin
      ir  = 16'h7FFF;
      sat = 1'b1;
    end else if (lm && mac_s[MAC_W-1]) begin
      ir  = '0;
      sat = 1'b1;
    end else if (mac_s < -32'sd32768) begin
      ir  = 16'h8000;
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      pos_sticky <= 1'b0;
      neg_sticky <= 1'b0;
    end else if (en) begin
      acc        <= wrapped;
      pos_sticky <= pos_ovf;
      neg_sticky <= neg_ovf;
    end
  end

endmodule

// File: rtl/gte_mac_accum.sv
// GTE MAC accumulator: sums one signed product per lane per beat into three
// 44-bit accumulators, then registers MAC1..3, saturated IR1..3 and FLAG bits.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid/i_first/i_last  beat framing
//   i_useBias               with i_first: preload bias<<12
//   i_sf, i_lm              shift and IR lower-clamp select (used on last beat)
//   i_prod0..2, i_bias0..2  lane products and biases
//   o_busy                  operation in progress
//   o_valid                 one-cycle result strobe
//   o_mac1..3, o_ir1..3     results, held until the next result
//   o_flags                 {MAC pos ovf[8:6], MAC neg ovf[5:3], IR sat[2:0]}
//
// state    | meaning
// ST_IDLE  | no operation open; only a first beat is accepted
// ST_ACCUM | operation open, waiting for further beats or the last beat
module gte_mac_accum
  import gte_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_first,
  input  logic              i_last,
  input  logic              i_useBias,
  input  logic              i_sf,
  input  logic              i_lm,
  input  logic [PROD_W-1:0] i_prod0,
  input  logic [PROD_W-1:0] i_prod1,
  input  logic [PROD_W-1:0] i_prod2,
  input  logic [BIAS_W-1:0] i_bias0,
  input  logic [BIAS_W-1:0] i_bias1,
  input  logic [BIAS_W-1:0] i_bias2,
  output logic              o_busy,
  output logic              o_valid,
  output logic [MAC_W-1:0]  o_mac1,
  output logic [MAC_W-1:0]  o_mac2,
  output logic [MAC_W-1:0]  o_mac3,
  output logic [IR_W-1:0]   o_ir1,
  output logic [IR_W-1:0]   o_ir2,
  output logic [IR_W-1:0]   o_ir3,
  output logic [8:0]        o_flags
);

  acc_state_t        state;
  acc_state_t        state_nx;
  logic              accept;
  logic              done;
  logic [PROD_W-1:0] prod  [3];
  logic [BIAS_W-1:0] bias  [3];
  logic [MAC_W-1:0]  mac   [3];
  logic [IR_W-1:0]   ir    [3];
  logic [2:0]        pos;
  logic [2:0]        neg;
  logic [2:0]        sat;

  assign prod[0] = i_prod0;
  assign prod[1] = i_prod1;
  assign prod[2] = i_prod2;
  assign bias[0] = i_bias0;
  assign bias[1] = i_bias1;
  assign bias[2] = i_bias2;

  // A first beat always (re)starts; a first beat in ST_ACCUM silently drops
  // the open operation since the lanes rebuild their base and sticky flags.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    done     = 1'b0;
    if (i_valid) begin
      if (i_first) begin
        accept   = 1'b1;
        done     = i_last;
        state_nx = i_last ? ST_IDLE : ST_ACCUM;
      end else if (state == ST_ACCUM) begin
        accept = 1'b1;
        if (i_last) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_lane
    gte_mac_lane u_lane (
      .clk      (i_clk),
      .rst      (i_rst),
      .en       (accept),
      .first    (i_first),
      .use_bias (i_useBias),
      .sf       (i_sf),
      .lm       (i_lm),
      .bias     (bias[g]),
      .prod     (prod[g]),
      .mac      (mac[g]),
      .ir       (ir[g]),
      .pos_ovf  (pos[g]),
      .neg_ovf  (neg[g]),
      .sat      (sat[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      o_valid <= 1'b0;
      o_mac1  <= '0;
      o_mac2  <= '0;
      o_mac3  <= '0;
      o_ir1   <= '0;
      o_ir2   <= '0;
      o_ir3   <= '0;
      o_flags <= '0;
    end else begin
      state   <= state_nx;
      o_valid <= done;
      if (done) begin
        o_mac1  <= mac[0];
        o_mac2  <= mac[1];
        o_mac3  <= mac[2];
        o_ir1   <= ir[0];
        o_ir2   <= ir[1];
        o_ir3   <= ir[2];
        o_flags <= {pos[0], pos[1], pos[2], neg[0], neg[1], neg[2],
                    sat[0], sat[1], sat[2]};
      end
    end
  end

  assign o_busy = (state == ST_ACCUM);

endmodule

// File: tb/tb_gte_mac_accum.sv
// Self-checking bench for gte_mac_accum: directed cases with literal
// expectations, then randomized beats checked every cycle against an
// arithmetic reference model.
module tb_gte_mac_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid, first, last, use_bias, sf, lm;
  logic signed [34:0] prod [3];
  logic signed [31:0] bias [3];
  logic        busy, ovalid;
  logic [31:0] mac1, mac2, mac3;
  logic [15:0] ir1, ir2, ir3;
  logic [8:0]  flags;

  int vectors = 0;
  int errors  = 0;
  bit checking = 1'b0;

  gte_mac_accum dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_first(first), .i_last(last),
    .i_useBias(use_bias), .i_sf(sf), .i_lm(lm),
    .i_prod0(prod[0]), .i_prod1(prod[1]), .i_prod2(prod[2]),
    .i_bias0(bias[0]), .i_bias1(bias[1]), .i_bias2(bias[2]),
    .o_busy(busy), .o_valid(ovalid),
    .o_mac1(mac1), .o_mac2(mac2), .o_mac3(mac3),
    .o_ir1(ir1), .o_ir2(ir2), .o_ir3(ir3), .o_flags(flags)
  );

  // ---------------- reference model ----------------
  localparam longint ACC_MAX = 64'sd8796093022207;   //  2^43 - 1
  localparam longint ACC_MIN = -64'sd8796093022208;  // -2^43

  longint      acc_m [3];
  bit          po [3], ng [3], st [3];
  bit          m_busy, m_valid;
  logic [31:0] m_mac [3];
  logic [15:0] m_ir [3];
  logic [8:0]  m_flags;
  longint      mb, ms, mm;
  logic signed [31:0] m32;
  int          lo;

  function automatic longint wrap44(longint s);
    logic signed [43:0] t;
    t = s[43:0];
    return longint'(t);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_flags = '0;
      for (int n = 0; n < 3; n++) begin
        acc_m[n] = 0; po[n] = 0; ng[n] = 0; m_mac[n] = '0; m_ir[n] = '0;
      end
    end else begin
      m_valid = 0;
      if (valid && (first || m_busy)) begin
        for (int n = 0; n < 3; n++) begin
          if (first) begin
            mb = use_bias ? longint'(bias[n]) * 4096 : 0;
            po[n] = 0; ng[n] = 0;
          end else begin
            mb = acc_m[n];
          end
          ms = mb + longint'(prod[n]);
          if (ms > ACC_MAX) po[n] = 1;
          if (ms < ACC_MIN) ng[n] = 1;
          acc_m[n] = wrap44(ms);
        end
        if (last) begin
          for (int n = 0; n < 3; n++) begin
            mm  = sf ? (acc_m[n] >>> 12) : acc_m[n];
            m32 = mm[31:0];
            lo  = lm ? 0 : -32768;
            st[n] = 1;
            if (m32 > 32767)   m_ir[n] = 16'h7FFF;
            else if (m32 < lo) m_ir[n] = lo[15:0];
            else begin         m_ir[n] = m32[15:0]; st[n] = 0; end
            m_mac[n] = m32;
          end
          m_flags = {po[0], po[1], po[2], ng[0], ng[1], ng[2], st[0], st[1], st[2]};
          m_valid = 1;
          m_busy  = 0;
        end else begin
          m_busy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if (ovalid !== m_valid || busy !== m_busy || mac1 !== m_mac[0] ||
          mac2 !== m_mac[1] || mac3 !== m_mac[2] || ir1 !== m_ir[0] ||
          ir2 !== m_ir[1] || ir3 !== m_ir[2] || flags !== m_flags) begin
        errors++;
        $display("FAIL cycle t=%0t dut v=%b b=%b mac=%h/%h/%h ir=%h/%h/%h fl=%b | model v=%b b=%b mac=%h/%h/%h ir=%h/%h/%h fl=%b",
                 $time, ovalid, busy, mac1, mac2, mac3, ir1, ir2, ir3, flags,
                 m_valid, m_busy, m_mac[0], m_mac[1], m_mac[2], m_ir[0], m_ir[1], m_ir[2], m_flags);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat(bit v, bit f, bit l, bit ub, bit s, bit m,
                      longint p0, longint p1, longint p2,
                      longint b0, longint b1, longint b2);
    valid = v; first = f; last = l; use_bias = ub; sf = s; lm = m;
    prod[0] = p0[34:0]; prod[1] = p1[34:0]; prod[2] = p2[34:0];
    bias[0] = b0[31:0]; bias[1] = b1[31:0]; bias[2] = b2[31:0];
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) beat(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [63:0] r0, r1, r2;
  longint      p [3];

  initial begin
    rst = 1; valid = 0; first = 0; last = 0; use_bias = 0; sf = 0; lm = 0;
    for (int n = 0; n < 3; n++) begin prod[n] = '0; bias[n] = '0; end
    @(posedge clk); #1;
    checking = 1;
    @(posedge clk); #1;
    rst = 0;

    chk("reset_mac1", mac1, 0);
    chk("reset_ir3", {16'h0, ir3}, 0);
    chk("reset_flags", {23'h0, flags}, 0);
    chk("reset_busy_valid", {30'h0, busy, ovalid}, 0);

    // single beat, sf=1
    beat(1, 1, 1, 0, 1, 0, 64'h3000000, 0, 0, 0, 0, 0);
    chk("single_valid", {31'h0, ovalid}, 1);
    chk("single_mac1", mac1, 32'h3000);
    chk("single_ir1", {16'h0, ir1}, 32'h3000);
    chk("single_flags", {23'h0, flags}, 0);
    idle(1);
    chk("single_valid_drop", {31'h0, ovalid}, 0);
    chk("single_hold_mac1", mac1, 32'h3000);

    // 3-beat row with bias preload
    beat(1, 1, 0, 1, 1, 0, 4096, 0, 0, 100, 0, 0);
    chk("row_busy1", {31'h0, busy}, 1);
    beat(1, 0, 0, 1, 1, 0, 8192, 0, 0, 100, 0, 0);
    chk("row_busy2", {31'h0, busy}, 1);
    beat(1, 0, 1, 1, 1, 0, -4096, 0, 0, 100, 0, 0);
    chk("row_mac1", mac1, 102);
    chk("row_flags", {23'h0, flags}, 0);
    chk("row_busy_end", {31'h0, busy}, 0);

    // IR saturation
    beat(1, 1, 1, 0, 0, 0, 0, 40000, 0, 0, 0, 0);
    chk("sat_ir2", {16'h0, ir2}, 32'h7FFF);
    chk("sat_flags_ir2", {23'h0, flags}, 9'b000000010);
    beat(1, 1, 1, 0, 0, 1, 0, 0, -5, 0, 0, 0);
    chk("sat_ir3_lm", {16'h0, ir3}, 0);
    chk("sat_flags_ir3", {23'h0, flags}, 9'b000000001);
    beat(1, 1, 1, 0, 0, 0, 0, 0, -5, 0, 0, 0);
    chk("nosat_ir3", {16'h0, ir3}, 32'h0000FFFB);
    chk("nosat_flags", {23'h0, flags}, 0);

    // positive accumulator overflow
    beat(1, 1, 0, 1, 0, 0, 0, 0, 0, 64'h7FFFFFFF, 0, 0);
    beat(1, 0, 0, 0, 0, 0, 64'sd17179869183, 0, 0, 0, 0, 0);
    beat(1, 0, 1, 0, 0, 0, 64'sd17179869183, 0, 0, 0, 0, 0);
    chk("pos_ovf_flag8", {31'h0, flags[8]}, 1);
    chk("pos_ovf_flag5", {31'h0, flags[5]}, 0);

    // negative mirror
    beat(1, 1, 0, 1, 0, 0, 0, 0, 0, 64'h80000000, 0, 0);
    beat(1, 0, 1, 0, 0, 0, -64'sd17179869184, 0, 0, 0, 0, 0);
    chk("neg_ovf_flag5", {31'h0, flags[5]}, 1);
    chk("neg_ovf_flag8", {31'h0, flags[8]}, 0);

    // restart after stall; only the second operation reports
    beat(1, 1, 0, 0, 0, 0, 1000, 0, 0, 0, 0, 0);
    idle(3);
    chk("stall_no_valid", {31'h0, ovalid}, 0);
    beat(1, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    beat(1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    chk("restart_valid", {31'h0, ovalid}, 1);
    chk("restart_mac1", mac1, 10);
    idle(1);
    beat(1, 0, 1, 0, 0, 0, 55, 0, 0, 0, 0, 0);
    chk("stray_beat_valid", {31'h0, ovalid}, 0);
    idle(1);
    chk("stray_beat_valid2", {31'h0, ovalid}, 0);
    chk("stray_beat_mac1", mac1, 10);

    // reset mid-operation, reset beats a simultaneous last beat
    beat(1, 1, 0, 0, 0, 0, 500, 0, 0, 0, 0, 0);
    rst = 1;
    beat(1, 0, 1, 0, 0, 0, 9, 0, 0, 0, 0, 0);
    rst = 0;
    chk("rst_mid_valid", {31'h0, ovalid}, 0);
    chk("rst_mid_mac1", mac1, 0);
    chk("rst_mid_busy", {31'h0, busy}, 0);
    idle(2);
    chk("rst_mid_valid_after", {31'h0, ovalid}, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        p[0] = longint'($urandom_range(0, 200000)) - 100000;
        p[1] = longint'($urandom_range(0, 200000)) - 100000;
        p[2] = longint'($urandom_range(0, 200000)) - 100000;
      end else begin
        p[0] = longint'(r0); p[1] = longint'(r1); p[2] = longint'(r2);
      end
      rst = ($urandom_range(0, 199) == 0);
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           p[0], p[1], p[2],
           longint'($urandom), longint'($urandom), longint'($urandom));
    end
    rst = 0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
